// File: rtl/insn_fetch.sv
// Instruction fetch unit: in-order word requests with credit-based flow control,
// a {pc, insn} buffer FIFO, a one-entry output register, and branch redirect/flush.
module insn_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  br_taken,
  input  logic [ADDR_WIDTH-1:0] br_addr,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [31:0]           imem_rdata,
  output logic                  if_valid,
  output logic [31:0]           if_insn,
  output logic [ADDR_WIDTH-1:0] if_pc
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         discard_cnt;
  logic [CW-1:0]         fifo_cnt;
  logic [PW-1:0]         fifo_wr, fifo_rd;
  logic [PW-1:0]         pcq_wr, pcq_rd;
  logic [ADDR_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
  logic [31:0]           fifo_insn [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pcq       [FIFO_DEPTH];

  logic          redir;
  logic          grant;
  logic          rsp_any;
  logic          rsp_drop;
  logic          rsp_acc;
  logic          fifo_pop;
  logic          fifo_push;
  logic          bypass;
  logic [CW:0]   credit_used;
  logic          br_addr_unused;

  assign br_addr_unused = ^br_addr[1:0];

  // Request side: a request is only issued when a slot is guaranteed for its response.
  assign redir       = br_taken & if_valid & ~stall;
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_cnt};
  assign imem_req    = ~rst & ~redir & (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr   = fetch_pc;
  assign grant       = imem_req & imem_gnt;

  // Response side: stale words (issued before a redirect) are dropped by count.
  assign rsp_any   = imem_rvalid & (outstanding != '0);
  assign rsp_drop  = rsp_any & (redir | (discard_cnt != '0));
  assign rsp_acc   = rsp_any & ~rsp_drop;
  assign fifo_pop  = ~stall & ~redir & (fifo_cnt != '0);
  assign bypass    = ~stall & ~redir & (fifo_cnt == '0) & rsp_acc;
  assign fifo_push = rsp_acc & ~bypass;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
      fifo_cnt    <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
    end else if (redir) begin
      fetch_pc    <= {br_addr[ADDR_WIDTH-1:2], 2'b00};
      outstanding <= outstanding - CW'(rsp_any);
      discard_cnt <= outstanding - CW'(rsp_any);
      fifo_cnt    <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
    end else begin
      if (grant)
        fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
      outstanding <= outstanding + CW'(grant) - CW'(rsp_any);
      if (rsp_drop)
        discard_cnt <= discard_cnt - CW'(1);
      if (grant)
        pcq_wr <= pcq_wr + PW'(1);
      if (rsp_acc)
        pcq_rd <= pcq_rd + PW'(1);
      if (fifo_push)
        fifo_wr <= fifo_wr + PW'(1);
      if (fifo_pop)
        fifo_rd <= fifo_rd + PW'(1);
      fifo_cnt <= fifo_cnt + CW'(fifo_push) - CW'(fifo_pop);
    end
  end

  // Storage arrays carry no reset; occupancy is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (grant)
      pcq[pcq_wr] <= fetch_pc;
    if (fifo_push) begin
      fifo_pc[fifo_wr]   <= pcq[pcq_rd];
      fifo_insn[fifo_wr] <= imem_rdata;
    end
  end

  // Output stage: FIFO head first, then same-cycle bypass, otherwise a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_insn  <= NOP;
      if_pc    <= '0;
    end else if (!stall) begin
      if (fifo_pop) begin
        if_valid <= 1'b1;
        if_insn  <= fifo_insn[fifo_rd];
        if_pc    <= fifo_pc[fifo_rd];
      end else if (bypass) begin
        if_valid <= 1'b1;
        if_insn  <= imem_rdata;
        if_pc    <= pcq[pcq_rd];
      end else begin
        if_valid <= 1'b0;
        if_insn  <= NOP;
      end
    end
  end

endmodule

// File: tb/tb_insn_fetch.sv
// Self-checking bench for insn_fetch: memory responder with configurable latency,
// a program-order stream model, and directed cycle-exact checks.
module tb_insn_fetch;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int          DEPTH  = 2;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_insn;
  logic [31:0] if_pc;

  insn_fetch #(
    .ADDR_WIDTH (32),
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_addr     (br_addr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_insn     (if_insn),
    .if_pc       (if_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  int    cyc    = 0;
  int    n_new  = 0;
  bit    inject = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #2;
    cyc++;
  endtask

  // Memory responder: in-order responses, each at least `lat` cycles after its grant.
  task automatic mem_drive(input bit rnd, input int lat);
    mreq_t m;
    if (rst)
      mq.delete();
    if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
      m           = mq.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(m.addr);
    end else begin
      imem_rvalid = inject;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    inject   = 1'b0;
    imem_gnt = rnd ? 1'($urandom_range(1)) : 1'b1;
    #1;
    if (imem_req && imem_gnt) begin
      m.addr = imem_addr;
      m.due  = cyc + lat;
      mq.push_back(m);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] ba,
                      input bit rnd, input int lat);
    next_cycle();
    rst      = r;
    stall    = s;
    br_taken = b;
    br_addr  = ba;
    mem_drive(rnd, lat);
  endtask

  // Stream model: valid instructions must appear in program order starting at
  // RST_PC, restarting at the aligned target after each accepted redirect.
  logic        p_valid = 1'b0;
  logic [31:0] p_pc    = '0;
  logic [31:0] p_insn  = NOP;
  logic [31:0] exp_pc  = RST_PC;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_insn", if_insn, NOP);
      chk("rst_pc", if_pc, 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      exp_pc = RST_PC;
    end else if (stall) begin
      chk("hold_valid", 32'(if_valid), 32'(p_valid));
      chk("hold_insn", if_insn, p_insn);
      chk("hold_pc", if_pc, p_pc);
    end else if (br_taken && p_valid) begin
      chk("redir_valid", 32'(if_valid), 32'd0);
      chk("redir_insn", if_insn, NOP);
      chk("redir_pc", if_pc, p_pc);
      exp_pc = {br_addr[31:2], 2'b00};
    end else if (if_valid) begin
      chk("stream_pc", if_pc, exp_pc);
      chk("stream_insn", if_insn, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_new++;
    end else begin
      chk("bubble_insn", if_insn, NOP);
      chk("bubble_pc", if_pc, p_pc);
    end
    chk("inflight_bound", 32'(mq.size() <= DEPTH), 32'd1);
    p_valid = if_valid;
    p_pc    = if_pc;
    p_insn  = if_insn;
  end

  initial begin
    bit s;
    bit b;
    bit did_br;
    int n0;
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_addr = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // Reset with stray response pulses
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      rst = 1'b1;
      inject = (i != 1);
      mem_drive(1'b0, 1);
    end

    // Release: stray response with nothing outstanding must be ignored
    next_cycle();
    rst = 1'b0;
    inject = 1'b1;
    mem_drive(1'b0, 1);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, RST_PC);
    step(0, 0, 0, 0, 0, 1);
    chk("latency_bubble", 32'(if_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1);
      chk("wrap_pc", if_pc, RST_PC + 32'(4 * i));
      chk("wrap_valid", 32'(if_valid), 32'd1);
    end

    // Stall 4 cycles starting with pc 8 on the outputs
    step(0, 1, 0, 0, 0, 1);
    chk("stall_pc", if_pc, 32'h8);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0, 1);
      chk("stall_req_low", 32'(imem_req), 32'd0);
    end
    step(0, 0, 0, 0, 0, 1);
    chk("release_req_low", 32'(imem_req), 32'd0);
    chk("release_pc", if_pc, 32'h8);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1);
      chk("after_stall_pc", if_pc, 32'hC + 32'(4 * i));
      chk("after_stall_valid", 32'(if_valid), 32'd1);
    end

    // Redirect to 0x103 with one word in flight
    step(0, 0, 1, 32'h103, 0, 1);
    chk("redir_at_pc", if_pc, 32'h1C);
    chk("redir_no_req", 32'(imem_req), 32'd0);
    step(0, 0, 0, 0, 0, 1);
    chk("tgt_bubble1", 32'(if_valid), 32'd0);
    chk("tgt_req", 32'(imem_req), 32'd1);
    chk("tgt_addr", imem_addr, 32'h100);
    step(0, 0, 0, 0, 0, 1);
    chk("tgt_bubble2", 32'(if_valid), 32'd0);
    step(0, 0, 0, 0, 0, 1);
    chk("tgt_valid", 32'(if_valid), 32'd1);
    chk("tgt_pc", if_pc, 32'h100);
    chk("tgt_insn", if_insn, 32'h5A00_0103);
    step(0, 0, 0, 0, 0, 1);
    chk("tgt_next_pc", if_pc, 32'h104);

    // Branch request while stalled is ignored
    step(0, 1, 1, 32'h500, 0, 1);
    chk("stall_br_pc", if_pc, 32'h108);
    step(0, 1, 1, 32'h500, 0, 1);
    chk("stall_br_hold", if_pc, 32'h108);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("stall_br_ignored", if_pc, 32'h10C);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);

    // Slow memory, random grant, random stall, one redirect mid-stream
    did_br = 1'b0;
    n0 = n_new;
    for (int i = 0; i < 80; i++) begin
      next_cycle();
      s = ($urandom_range(7) == 0);
      b = (i >= 40) && !did_br && if_valid && !s;
      if (b) did_br = 1'b1;
      rst      = 1'b0;
      stall    = s;
      br_taken = b;
      br_addr  = 32'h2003;
      mem_drive(1'b1, 3);
    end
    chk("slow_redirect_taken", 32'(did_br), 32'd1);
    chk("slow_progress", 32'((n_new - n0) >= 10), 32'd1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1);

    // Reset mid-stream, then restart from RST_PC
    step(1, 0, 0, 0, 0, 1);
    inject = 1'b1;
    step(1, 0, 0, 0, 0, 1);
    next_cycle();
    rst = 1'b0; stall = 1'b0; br_taken = 1'b0;
    inject = 1'b1;
    mem_drive(1'b0, 1);
    chk("restart_addr", imem_addr, RST_PC);
    chk("restart_req", 32'(imem_req), 32'd1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("restart_pc", if_pc, RST_PC);
    chk("restart_insn", if_insn, 32'hA5FF_FFFB);
    step(0, 0, 0, 0, 0, 1);
    chk("restart_pc2", if_pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 1);
    chk("restart_wrap", if_pc, 32'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);

    @(negedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
